// File: rtl/riscv_aes_pkg.sv
// Types and the word-select helper shared by the AES-128 register-file sequencer.
// Words are numbered MSB-first: word0 = [127:96] ... word3 = [31:0].
package riscv_aes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_DATA,
      START,
      WAIT,
      RESP
   } aes_seq_state_e;

   localparam int   AES_BLOCK_W = 128;
   localparam int   AES_WORDS   = 4;
   localparam logic RF_SEL_DATA = 1'b0;
   localparam logic RF_SEL_KEY  = 1'b1;

   function automatic logic [AES_BLOCK_W/AES_WORDS-1:0] aes_word_sel(
      input logic [AES_BLOCK_W-1:0] blk,
      input logic [1:0]             idx
   );
      logic [AES_BLOCK_W/AES_WORDS-1:0] w;
      case (idx)
         2'd0:    w = blk[127:96];
         2'd1:    w = blk[95:64];
         2'd2:    w = blk[63:32];
         default: w = blk[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/riscv_aes_sequencer.sv
// Runs one AES-128 op: key/data words into the register file, start pulse, capture after CIPHER_LATENCY.
// Latency handshake->rsp_valid_o 10+CIPHER_LATENCY (6+CIPHER_LATENCY on a key-cache hit with AES_SEQ_KEY_CACHE_EN).
// Backpressure: req_ready_o only in IDLE; rsp_data_o holds until rsp_ready_i.
module riscv_aes_sequencer
   import riscv_aes_pkg::*;
#(
   parameter int ADDR_WIDTH     = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int CIPHER_LATENCY = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AES_BLOCK_W-1:0] req_data_i,
   input  logic [AES_BLOCK_W-1:0] req_key_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [AES_BLOCK_W-1:0] rsp_data_o,
   output logic                   busy_o,
   output logic [ADDR_WIDTH-1:0]  rf_waddr_o,
   output logic [DATA_WIDTH-1:0]  rf_wdata_o,
   output logic                   rf_wen_o,
   output logic                   rf_sel_o,
   output logic                   rf_aes_start_o,
   input  logic [AES_BLOCK_W-1:0] cipher_data_i
);

   localparam int WAIT_W = $clog2(CIPHER_LATENCY + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(AES_WORDS - 1);

   aes_seq_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic [AES_BLOCK_W-1:0] data_q, data_d;
   logic [AES_BLOCK_W-1:0] key_q, key_d;
   logic [AES_BLOCK_W-1:0] rsp_q, rsp_d;
`ifdef AES_SEQ_KEY_CACHE_EN
   logic [AES_BLOCK_W-1:0] key_cache_q, key_cache_d;
   logic                   key_cache_vld_q, key_cache_vld_d;
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      wait_d         = wait_q;
      data_d         = data_q;
      key_d          = key_q;
      rsp_d          = rsp_q;
`ifdef AES_SEQ_KEY_CACHE_EN
      key_cache_d     = key_cache_q;
      key_cache_vld_d = key_cache_vld_q;
`endif
      req_ready_o    = 1'b0;
      rsp_valid_o    = 1'b0;
      busy_o         = 1'b1;
      rf_waddr_o     = '0;
      rf_wdata_o     = '0;
      rf_wen_o       = 1'b0;
      rf_sel_o       = RF_SEL_DATA;
      rf_aes_start_o = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (req_valid_i) begin
               data_d  = req_data_i;
               key_d   = req_key_i;
               cnt_d   = '0;
               state_d = LOAD_KEY;
`ifdef AES_SEQ_KEY_CACHE_EN
               if (key_cache_vld_q && (req_key_i == key_cache_q)) state_d = LOAD_DATA;
`endif
            end
         end
         LOAD_KEY: begin
            rf_wen_o   = 1'b1;
            rf_sel_o   = RF_SEL_KEY;
            rf_waddr_o = cnt_q;
            rf_wdata_o = aes_word_sel(key_q, cnt_q);
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d = LOAD_DATA;
`ifdef AES_SEQ_KEY_CACHE_EN
               key_cache_d     = key_q;
               key_cache_vld_d = 1'b1;
`endif
            end
         end
         LOAD_DATA: begin
            rf_wen_o   = 1'b1;
            rf_sel_o   = RF_SEL_DATA;
            rf_waddr_o = cnt_q;
            rf_wdata_o = aes_word_sel(data_q, cnt_q);
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) state_d = START;
         end
         START: begin
            rf_aes_start_o = 1'b1;
            wait_d         = WAIT_W'(CIPHER_LATENCY - 1);
            state_d        = WAIT;
         end
         WAIT: begin
            // counter reaches zero in the cycle the cipher output is valid
            if (wait_q == '0) begin
               rsp_d   = cipher_data_i;
               state_d = RESP;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rsp_data_o = rsp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wait_q  <= '0;
         data_q  <= '0;
         key_q   <= '0;
         rsp_q   <= '0;
`ifdef AES_SEQ_KEY_CACHE_EN
         key_cache_q     <= '0;
         key_cache_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         data_q  <= data_d;
         key_q   <= key_d;
         rsp_q   <= rsp_d;
`ifdef AES_SEQ_KEY_CACHE_EN
         key_cache_q     <= key_cache_d;
         key_cache_vld_q <= key_cache_vld_d;
`endif
      end
   end

endmodule

// File: tb/tb_riscv_aes_sequencer.sv
// Bench for riscv_aes_sequencer: register-file/cipher stand-in plus a response scoreboard.
// Honors AES_SEQ_KEY_CACHE_EN the same way as the design.
module tb_riscv_aes_sequencer;

   localparam int L = 11;
   localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] FIPS_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] FIPS_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
   localparam logic [127:0] GARBAGE  = {4{32'hdeadbeef}};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid_i = 1'b0;
   logic         req_ready_o;
   logic [127:0] req_data_i = '0;
   logic [127:0] req_key_i = '0;
   logic         rsp_valid_o;
   logic         rsp_ready_i = 1'b1;
   logic [127:0] rsp_data_o;
   logic         busy_o;
   logic [1:0]   rf_waddr_o;
   logic [31:0]  rf_wdata_o;
   logic         rf_wen_o;
   logic         rf_sel_o;
   logic         rf_aes_start_o;
   logic [127:0] cipher_data_i;

   riscv_aes_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .CIPHER_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_data_i(req_data_i), .req_key_i(req_key_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
      .busy_o(busy_o),
      .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_wen_o(rf_wen_o),
      .rf_sel_o(rf_sel_o), .rf_aes_start_o(rf_aes_start_o),
      .cipher_data_i(cipher_data_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] ct;
      int           lat;
   } exp_t;
   exp_t sb_q[$];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] d);
      if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
      return k ^ {d[63:0], d[127:64]} ^ {4{32'ha5c3_1e0f}};
   endfunction

   function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
      logic [127:0] s;
      s = b >> (32 * (3 - i));
      return s[31:0];
   endfunction

   // Current-op context shared between driver and monitor
   logic [127:0] cur_key = '0, cur_dat = '0;
   bit           cur_skip = 0;
   int           acc_cyc = 0, start_cyc = -1000;
   int           key_wr = 0, dat_wr = 0, total_wr = 0;
   logic [31:0]  rf_key[4];
   logic [31:0]  rf_dat[4];
`ifdef AES_SEQ_KEY_CACHE_EN
   logic [127:0] bc_key = '0;
   bit           bc_vld = 0;
`endif

   // Monitor: register-file/cipher stand-in and scoreboard checker
   initial begin
      bit prev_rsp, prev_start;
      int a;
      exp_t e;
      prev_rsp = 0;
      prev_start = 0;
      cipher_data_i = GARBAGE;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_rsp = 0;
            prev_start = 0;
            start_cyc = -1000;
            cipher_data_i = GARBAGE;
         end else begin
            chk("busy_vs_ready", busy_o, !req_ready_o);
            if (req_valid_i && req_ready_o) begin
               acc_cyc = cyc;
               key_wr = 0;
               dat_wr = 0;
            end
            if (rf_wen_o) begin
               a = int'(rf_waddr_o);
               total_wr++;
               if (rf_sel_o) begin
                  chk("key_addr", rf_waddr_o, key_wr);
                  chk("key_word", rf_wdata_o, word_of(cur_key, a));
                  chk("key_cyc", cyc - acc_cyc, 1 + key_wr);
                  rf_key[a] = rf_wdata_o;
                  key_wr++;
               end else begin
                  chk("dat_addr", rf_waddr_o, dat_wr);
                  chk("dat_word", rf_wdata_o, word_of(cur_dat, a));
                  chk("dat_cyc", cyc - acc_cyc, (cur_skip ? 1 : 5) + dat_wr);
                  rf_dat[a] = rf_wdata_o;
                  dat_wr++;
               end
            end else begin
               chk("waddr_idle", rf_waddr_o, 0);
            end
            if (rf_aes_start_o) begin
               start_cyc = cyc;
               chk("start_cyc", cyc - acc_cyc, cur_skip ? 5 : 9);
               chk("start_pulse", prev_start, 0);
            end
            prev_start = rf_aes_start_o;
            cipher_data_i = (cyc == start_cyc + L)
               ? model_ct({rf_key[0], rf_key[1], rf_key[2], rf_key[3]},
                          {rf_dat[0], rf_dat[1], rf_dat[2], rf_dat[3]})
               : GARBAGE;
            if (rsp_valid_o && !prev_rsp) begin
               if (sb_q.size() == 0) begin
                  chk("sb_unexpected_rsp", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  chk("rsp_data", rsp_data_o, e.ct);
                  chk("rsp_cyc", cyc - acc_cyc, e.lat);
               end
            end
            prev_rsp = rsp_valid_o;
         end
      end
   end

   task automatic send_req(input logic [127:0] k, input logic [127:0] d);
      exp_t e;
      int n;
      bit skip;
      skip = 0;
`ifdef AES_SEQ_KEY_CACHE_EN
      skip = bc_vld && (k == bc_key);
      bc_key = k;
      bc_vld = 1;
`endif
      cur_key = k;
      cur_dat = d;
      cur_skip = skip;
      e.ct = model_ct(k, d);
      e.lat = skip ? 6 + L : 10 + L;
      sb_q.push_back(e);
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      req_key_i = k;
      req_data_i = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready_o && n < 200);
      if (n >= 200) chk("req_accept_timeout", 0, 1);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic finish_op();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rsp_valid_o && rsp_ready_i) && n < 200);
      if (n >= 200) chk("rsp_timeout", 0, 1);
      @(posedge clk); #1;
      chk("key_wr_cnt", key_wr, cur_skip ? 0 : 4);
      chk("dat_wr_cnt", dat_wr, 4);
      chk("idle_after_op", req_ready_o, 1);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_req_ready"}, req_ready_o, 1);
      chk({pfx, "_rsp_valid"}, rsp_valid_o, 0);
      chk({pfx, "_rsp_data"}, rsp_data_o, 0);
      chk({pfx, "_busy"}, busy_o, 0);
      chk({pfx, "_wen"}, rf_wen_o, 0);
      chk({pfx, "_waddr"}, rf_waddr_o, 0);
      chk({pfx, "_wdata"}, rf_wdata_o, 0);
      chk({pfx, "_sel"}, rf_sel_o, 0);
      chk({pfx, "_start"}, rf_aes_start_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0, n;
      // Reset
      #12;
      chk_reset_outputs("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_writes", total_wr, 0);
      chk("post_rst_busy", busy_o, 0);

      // Single operation with the FIPS-197 vector
      rsp_ready_i = 1'b1;
      send_req(FIPS_KEY, FIPS_PT);
      finish_op();

      // Response backpressure and ignored second request
      rsp_ready_i = 1'b0;
      send_req(FIPS_KEY, FIPS_PT);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid_o && n < 200);
      if (n >= 200) chk("bp_rsp_timeout", 0, 1);
      wr0 = total_wr;
      repeat (5) begin
         @(posedge clk); #1;
         req_valid_i = 1'b1;
         req_key_i = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
         req_data_i = 128'h00112233_44556677_8899aabb_ccddeeff;
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid_o, 1);
         chk("bp_rsp_data", rsp_data_o, FIPS_CT);
         chk("bp_req_ready", req_ready_o, 0);
      end
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      finish_op();
      repeat (4) @(negedge clk);
      chk("bp_no_latch_writes", total_wr, wr0);
      chk("bp_idle", busy_o, 0);
      chk("bp_rsp_hold", rsp_data_o, FIPS_CT);

      // Reset in the middle of an operation, then a fresh request
      send_req(128'h000102030405060708090a0b0c0d0e0f, 128'hffeeddcc_bbaa9988_77665544_33221100);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      sb_q.delete();
`ifdef AES_SEQ_KEY_CACHE_EN
      bc_vld = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_req(FIPS_KEY, FIPS_PT);
      finish_op();

      // Same key twice, then a changed key
      send_req(128'h11111111_22222222_33333333_44444444, 128'h01234567_89abcdef_fedcba98_76543210);
      finish_op();
      send_req(128'h11111111_22222222_33333333_44444444, 128'hcafef00d_12345678_9abcdef0_0badbeef);
      finish_op();
      send_req(128'h55555555_66666666_77777777_88888888, 128'hcafef00d_12345678_9abcdef0_0badbeef);
      finish_op();

      chk("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
